// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the decode-to-execute operand fetch stage.
package pipeline_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam logic [4:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

    // x0 is hard-wired, so a producer targeting it never counts as a match.
    function automatic logic fwd_match(input logic [4:0] src, input logic src_valid,
                                       input logic [4:0] rd, input logic wr);
        return src_valid && (src != X0) && wr && (rd == src);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decoder, regfile, bypass and ID/EX signal bundle for operand_fetch_stage.
interface operand_fetch_stage_if;
    import pipeline_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic              in_rs1_valid;
    logic              in_rs2_valid;
    logic [4:0]        in_rd;
    logic              in_rd_wr;
    logic              in_is_load;

    logic [4:0]        rf_rs1;
    logic [4:0]        rf_rs2;
    logic              rf_rs1_valid;
    logic              rf_rs2_valid;
    logic [XLEN-1:0]   rf_rs1_value;
    logic [XLEN-1:0]   rf_rs2_value;

    logic [4:0]        fwd_ex_rd;
    logic              fwd_ex_wr;
    logic              fwd_ex_is_load;
    logic [XLEN-1:0]   fwd_ex_value;
    logic [4:0]        fwd_mem_rd;
    logic              fwd_mem_wr;
    logic [XLEN-1:0]   fwd_mem_value;
    logic [4:0]        fwd_wb_rd;
    logic              fwd_wb_wr;
    logic [XLEN-1:0]   fwd_wb_value;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_rs1_value;
    logic [XLEN-1:0]   out_rs2_value;
    logic [4:0]        out_rd;
    logic              out_rd_wr;
    logic              out_is_load;

    modport slave (
        input  in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2, in_rs1_valid, in_rs2_valid,
               in_rd, in_rd_wr, in_is_load,
               rf_rs1_value, rf_rs2_value,
               fwd_ex_rd, fwd_ex_wr, fwd_ex_is_load, fwd_ex_value,
               fwd_mem_rd, fwd_mem_wr, fwd_mem_value,
               fwd_wb_rd, fwd_wb_wr, fwd_wb_value,
               flush, out_ready,
        output in_ready, rf_rs1, rf_rs2, rf_rs1_valid, rf_rs2_valid,
               out_valid, out_pc, out_imm, out_ctrl, out_rs1_value, out_rs2_value,
               out_rd, out_rd_wr, out_is_load
    );

    modport master (
        output in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2, in_rs1_valid, in_rs2_valid,
               in_rd, in_rd_wr, in_is_load,
               rf_rs1_value, rf_rs2_value,
               fwd_ex_rd, fwd_ex_wr, fwd_ex_is_load, fwd_ex_value,
               fwd_mem_rd, fwd_mem_wr, fwd_mem_value,
               fwd_wb_rd, fwd_wb_wr, fwd_wb_value,
               flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2, rf_rs1_valid, rf_rs2_valid,
               out_valid, out_pc, out_imm, out_ctrl, out_rs1_value, out_rs2_value,
               out_rd, out_rd_wr, out_is_load
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-source operand select: EX > MEM > WB (when WB_FWD) > regfile, with x0/unused forced to zero.
module operand_fwd_mux
    import pipeline_pkg::*;
#(
    parameter bit WB_FWD = 1'b0
) (
    input  logic [4:0]      src,
    input  logic            src_valid,
    input  logic [XLEN-1:0] rf_value,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wr,
    input  logic [XLEN-1:0] ex_value,
    input  logic [4:0]      mem_rd,
    input  logic            mem_wr,
    input  logic [XLEN-1:0] mem_value,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wr,
    input  logic [XLEN-1:0] wb_value,
    output logic            ex_hit,
    output logic            wb_hit,
    output logic [XLEN-1:0] value
);

    logic     mem_hit;
    fwd_sel_t sel;

    assign ex_hit  = fwd_match(src, src_valid, ex_rd, ex_wr);
    assign mem_hit = fwd_match(src, src_valid, mem_rd, mem_wr);
    assign wb_hit  = fwd_match(src, src_valid, wb_rd, wb_wr);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit)
            sel = FWD_EX;
        else if (mem_hit)
            sel = FWD_MEM;
        else if (WB_FWD && wb_hit)
            sel = FWD_WB;
    end

    always_comb begin
        value = '0;
        if (src_valid && (src != X0)) begin
            case (sel)
                FWD_EX:  value = ex_value;
                FWD_MEM: value = mem_value;
                FWD_WB:  value = wb_value;
                default: value = rf_value;
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: regfile read, EX/MEM/WB bypass, load-use stall and the ID/EX register.
// WB_BYPASS_EN defined: WB is forwarded; undefined: a WB match stalls one cycle instead.
module operand_fetch_stage
    import pipeline_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    operand_fetch_stage_if.slave bus
);

`ifdef WB_BYPASS_EN
    localparam bit WB_FWD = 1'b1;
`else
    localparam bit WB_FWD = 1'b0;
`endif

    logic            ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic [XLEN-1:0] rs1_value, rs2_value;
    logic            advance, hazard, accept;

    assign bus.rf_rs1       = bus.in_rs1;
    assign bus.rf_rs2       = bus.in_rs2;
    assign bus.rf_rs1_valid = bus.in_rs1_valid & bus.in_valid;
    assign bus.rf_rs2_valid = bus.in_rs2_valid & bus.in_valid;

    operand_fwd_mux #(.WB_FWD(WB_FWD)) u_fwd_rs1 (
        .src       (bus.in_rs1),
        .src_valid (bus.in_rs1_valid),
        .rf_value  (bus.rf_rs1_value),
        .ex_rd     (bus.fwd_ex_rd),
        .ex_wr     (bus.fwd_ex_wr),
        .ex_value  (bus.fwd_ex_value),
        .mem_rd    (bus.fwd_mem_rd),
        .mem_wr    (bus.fwd_mem_wr),
        .mem_value (bus.fwd_mem_value),
        .wb_rd     (bus.fwd_wb_rd),
        .wb_wr     (bus.fwd_wb_wr),
        .wb_value  (bus.fwd_wb_value),
        .ex_hit    (ex_hit1),
        .wb_hit    (wb_hit1),
        .value     (rs1_value)
    );

    operand_fwd_mux #(.WB_FWD(WB_FWD)) u_fwd_rs2 (
        .src       (bus.in_rs2),
        .src_valid (bus.in_rs2_valid),
        .rf_value  (bus.rf_rs2_value),
        .ex_rd     (bus.fwd_ex_rd),
        .ex_wr     (bus.fwd_ex_wr),
        .ex_value  (bus.fwd_ex_value),
        .mem_rd    (bus.fwd_mem_rd),
        .mem_wr    (bus.fwd_mem_wr),
        .mem_value (bus.fwd_mem_value),
        .wb_rd     (bus.fwd_wb_rd),
        .wb_wr     (bus.fwd_wb_wr),
        .wb_value  (bus.fwd_wb_value),
        .ex_hit    (ex_hit2),
        .wb_hit    (wb_hit2),
        .value     (rs2_value)
    );

    // Without the WB bypass the regfile is still stale for a same-cycle write, so wait it out.
    assign hazard = bus.in_valid &
                    ((bus.fwd_ex_is_load & (ex_hit1 | ex_hit2)) |
                     (!WB_FWD & (wb_hit1 | wb_hit2)));
    assign advance      = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance & !hazard;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.out_pc        <= '0;
            bus.out_imm       <= '0;
            bus.out_ctrl      <= '0;
            bus.out_rs1_value <= '0;
            bus.out_rs2_value <= '0;
            bus.out_rd        <= '0;
            bus.out_rd_wr     <= 1'b0;
            bus.out_is_load   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= accept;
            if (accept) begin
                bus.out_pc        <= bus.in_pc;
                bus.out_imm       <= bus.in_imm;
                bus.out_ctrl      <= bus.in_ctrl;
                bus.out_rs1_value <= rs1_value;
                bus.out_rs2_value <= rs2_value;
                bus.out_rd        <= bus.in_rd;
                bus.out_rd_wr     <= bus.in_rd_wr;
                bus.out_is_load   <= bus.in_is_load;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a randomized run against a reference model.
module tb_operand_fetch_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: what the ID/EX register should hold.
    logic        exp_valid, exp_ready;
    logic [31:0] exp_pc, exp_imm, exp_rs1, exp_rs2;
    logic [15:0] exp_ctrl;
    logic [4:0]  exp_rd;
    logic        exp_rd_wr, exp_is_load;

    function automatic logic hits(input logic [4:0] src, input logic used,
                                  input logic [4:0] rd, input logic wr);
        return used && (src != 5'd0) && wr && (rd == src);
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic used,
                                                input logic [31:0] rfv);
        if (!used || src == 5'd0) return 32'd0;
        if (bus.fwd_ex_wr && bus.fwd_ex_rd == src) return bus.fwd_ex_value;
        if (bus.fwd_mem_wr && bus.fwd_mem_rd == src) return bus.fwd_mem_value;
`ifdef WB_BYPASS_EN
        if (bus.fwd_wb_wr && bus.fwd_wb_rd == src) return bus.fwd_wb_value;
`endif
        return rfv;
    endfunction

    function automatic logic ref_hazard();
        logic h;
        h = bus.fwd_ex_is_load &&
            (hits(bus.in_rs1, bus.in_rs1_valid, bus.fwd_ex_rd, bus.fwd_ex_wr) ||
             hits(bus.in_rs2, bus.in_rs2_valid, bus.fwd_ex_rd, bus.fwd_ex_wr));
`ifndef WB_BYPASS_EN
        h = h || hits(bus.in_rs1, bus.in_rs1_valid, bus.fwd_wb_rd, bus.fwd_wb_wr)
              || hits(bus.in_rs2, bus.in_rs2_valid, bus.fwd_wb_rd, bus.fwd_wb_wr);
`endif
        return bus.in_valid && h;
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_ready = 0; exp_pc = 0; exp_imm = 0; exp_rs1 = 0; exp_rs2 = 0;
        exp_ctrl = 0; exp_rd = 0; exp_rd_wr = 0; exp_is_load = 0;
    endtask

    // Computes exp_ready for the coming edge and the register contents after it.
    task automatic model_edge();
        logic adv, haz;
        adv = !exp_valid || bus.out_ready;
        haz = ref_hazard();
        exp_ready = adv && !haz;
        if (bus.flush) exp_valid = 0;
        else if (adv) begin
            if (bus.in_valid && !haz) begin
                exp_valid   = 1;
                exp_pc      = bus.in_pc;
                exp_imm     = bus.in_imm;
                exp_ctrl    = bus.in_ctrl;
                exp_rs1     = ref_operand(bus.in_rs1, bus.in_rs1_valid, bus.rf_rs1_value);
                exp_rs2     = ref_operand(bus.in_rs2, bus.in_rs2_valid, bus.rf_rs2_value);
                exp_rd      = bus.in_rd;
                exp_rd_wr   = bus.in_rd_wr;
                exp_is_load = bus.in_is_load;
            end else exp_valid = 0;
        end
    endtask

    task automatic clock();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_imm = 0; bus.in_ctrl = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rs1_valid = 0; bus.in_rs2_valid = 0;
        bus.in_rd = 0; bus.in_rd_wr = 0; bus.in_is_load = 0;
        bus.rf_rs1_value = 0; bus.rf_rs2_value = 0;
        bus.fwd_ex_rd = 0; bus.fwd_ex_wr = 0; bus.fwd_ex_is_load = 0; bus.fwd_ex_value = 0;
        bus.fwd_mem_rd = 0; bus.fwd_mem_wr = 0; bus.fwd_mem_value = 0;
        bus.fwd_wb_rd = 0; bus.fwd_wb_wr = 0; bus.fwd_wb_value = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                             input logic [4:0] rs2, input logic [31:0] v2, input logic [4:0] rd);
        bus.in_valid = 1; bus.in_pc = pc; bus.in_imm = $urandom; bus.in_ctrl = 16'($urandom);
        bus.in_rs1 = rs1; bus.in_rs1_valid = 1; bus.rf_rs1_value = v1;
        bus.in_rs2 = rs2; bus.in_rs2_valid = 1; bus.rf_rs2_value = v2;
        bus.in_rd = rd; bus.in_rd_wr = 1; bus.in_is_load = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_rs1_valid = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_rs1_value !== 32'd0) begin bad++; $display("FAIL reset_rs1 got=%h want=0", bus.out_rs1_value); end
        total++; if ({bus.out_pc, bus.out_ctrl, bus.out_rd, bus.out_rd_wr} !== '0) begin bad++; $display("FAIL reset_fields got=%h want=0", {bus.out_pc, bus.out_ctrl, bus.out_rd, bus.out_rd_wr}); end
        total++; if (bus.rf_rs1_valid !== 1'b0) begin bad++; $display("FAIL rf_valid_gate got=%0b want=0", bus.rf_rs1_valid); end
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_rf_read();
        idle_inputs();
        set_instr(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 5'd9);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rf_read_ready got=%0b want=1", bus.in_ready); end
        total++; if (bus.rf_rs1 !== 5'd1 || bus.rf_rs1_valid !== 1'b1) begin bad++; $display("FAIL rf_addr got=%0d/%0b want=1/1", bus.rf_rs1, bus.rf_rs1_valid); end
        clock();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rf_read_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.out_rs1_value !== 32'h11) begin bad++; $display("FAIL rf_read_rs1 got=%h want=11", bus.out_rs1_value); end
        total++; if (bus.out_pc !== 32'h100 || bus.out_rd !== 5'd9) begin bad++; $display("FAIL rf_read_pc got=%h/%0d want=100/9", bus.out_pc, bus.out_rd); end
    endtask

    task automatic test_ex_priority();
        idle_inputs();
        set_instr(32'h104, 5'd5, 32'h1, 5'd6, 32'h66, 5'd10);
        bus.fwd_ex_rd = 5; bus.fwd_ex_wr = 1; bus.fwd_ex_value = 32'hAA;
        bus.fwd_mem_rd = 5; bus.fwd_mem_wr = 1; bus.fwd_mem_value = 32'hBB;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ex_prio_ready got=%0b want=1", bus.in_ready); end
        clock();
        total++; if (bus.out_rs1_value !== 32'hAA) begin bad++; $display("FAIL ex_prio_rs1 got=%h want=aa", bus.out_rs1_value); end
        total++; if (bus.out_rs2_value !== 32'h66) begin bad++; $display("FAIL ex_prio_rs2 got=%h want=66", bus.out_rs2_value); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_instr(32'h108, 5'd1, 32'h1, 5'd7, 32'h0, 5'd11);
        bus.fwd_ex_rd = 7; bus.fwd_ex_wr = 1; bus.fwd_ex_is_load = 1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL load_use_ready got=%0b want=0", bus.in_ready); end
        clock();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL load_use_bubble got=%0b want=0", bus.out_valid); end
        bus.fwd_ex_wr = 0; bus.fwd_ex_is_load = 0;
        bus.fwd_mem_rd = 7; bus.fwd_mem_wr = 1; bus.fwd_mem_value = 32'h1234;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL load_use_retry got=%0b want=1", bus.in_ready); end
        clock();
        total++; if (bus.out_valid !== 1'b1 || bus.out_rs2_value !== 32'h1234) begin bad++; $display("FAIL load_use_rs2 got=%0b/%h want=1/1234", bus.out_valid, bus.out_rs2_value); end
    endtask

    task automatic test_x0();
        idle_inputs();
        set_instr(32'h10C, 5'd0, 32'h77, 5'd2, 32'h22, 5'd12);
        bus.fwd_ex_rd = 0; bus.fwd_ex_wr = 1; bus.fwd_ex_is_load = 1; bus.fwd_ex_value = 32'hFF;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b want=1", bus.in_ready); end
        clock();
        total++; if (bus.out_rs1_value !== 32'd0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL x0_rs1 got=%h/%0b want=0/1", bus.out_rs1_value, bus.out_valid); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        set_instr(32'h200, 5'd1, 32'h33, 5'd2, 32'h44, 5'd13);
        clock();
        set_instr(32'h300, 5'd3, 32'h99, 5'd4, 32'h98, 5'd14);
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b want=0", i, bus.in_ready); end
            clock();
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_rs1_value !== 32'h33) begin
                bad++; $display("FAIL stall_hold[%0d] got=%0b/%h/%h want=1/200/33", i, bus.out_valid, bus.out_pc, bus.out_rs1_value);
            end
        end
        bus.flush = 1;
        clock();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.out_valid); end
        bus.flush = 0;
    endtask

    task automatic test_wb();
        idle_inputs();
        set_instr(32'h400, 5'd3, 32'h0, 5'd2, 32'h22, 5'd15);
        bus.fwd_wb_rd = 3; bus.fwd_wb_wr = 1; bus.fwd_wb_value = 32'h55;
        #1;
`ifdef WB_BYPASS_EN
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL wb_ready got=%0b want=1", bus.in_ready); end
        clock();
`else
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL wb_stall got=%0b want=0", bus.in_ready); end
        clock();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wb_bubble got=%0b want=0", bus.out_valid); end
        bus.fwd_wb_wr = 0; bus.rf_rs1_value = 32'h55;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL wb_retry got=%0b want=1", bus.in_ready); end
        clock();
`endif
        total++; if (bus.out_valid !== 1'b1 || bus.out_rs1_value !== 32'h55) begin bad++; $display("FAIL wb_rs1 got=%0b/%h want=1/55", bus.out_valid, bus.out_rs1_value); end
    endtask

    task automatic test_random();
        logic [151:0] got, want;
        for (int n = 0; n < 600; n++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_pc = $urandom; bus.in_imm = $urandom; bus.in_ctrl = 16'($urandom);
            bus.in_rs1 = 5'($urandom_range(0, 3)); bus.in_rs2 = 5'($urandom_range(0, 3));
            bus.in_rs1_valid = 1'($urandom); bus.in_rs2_valid = 1'($urandom);
            bus.in_rd = 5'($urandom); bus.in_rd_wr = 1'($urandom); bus.in_is_load = 1'($urandom);
            bus.rf_rs1_value = $urandom; bus.rf_rs2_value = $urandom;
            bus.fwd_ex_rd = 5'($urandom_range(0, 3)); bus.fwd_ex_wr = 1'($urandom);
            bus.fwd_ex_is_load = ($urandom_range(0, 2) == 0); bus.fwd_ex_value = $urandom;
            bus.fwd_mem_rd = 5'($urandom_range(0, 3)); bus.fwd_mem_wr = 1'($urandom); bus.fwd_mem_value = $urandom;
            bus.fwd_wb_rd = 5'($urandom_range(0, 3)); bus.fwd_wb_wr = 1'($urandom); bus.fwd_wb_value = $urandom;
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 0;
                #1;
                model_reset();
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rand_reset[%0d] got=%0b want=0", n, bus.out_valid); end
                rst_n = 1;
                #1;
            end
            model_edge();
            total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL rand_ready[%0d] got=%0b want=%0b", n, bus.in_ready, exp_ready); end
            total++; if (bus.rf_rs2_valid !== (bus.in_rs2_valid & bus.in_valid) || bus.rf_rs2 !== bus.in_rs2) begin
                bad++; $display("FAIL rand_rf_port[%0d] got=%0b/%0d want=%0b/%0d", n, bus.rf_rs2_valid, bus.rf_rs2, bus.in_rs2_valid & bus.in_valid, bus.in_rs2);
            end
            @(posedge clk);
            #1;
            got  = {bus.out_valid, bus.out_pc, bus.out_imm, bus.out_ctrl, bus.out_rs1_value,
                    bus.out_rs2_value, bus.out_rd, bus.out_rd_wr, bus.out_is_load};
            want = {exp_valid, exp_pc, exp_imm, exp_ctrl, exp_rs1, exp_rs2, exp_rd, exp_rd_wr, exp_is_load};
            total++; if (got !== want) begin bad++; $display("FAIL rand_out[%0d] got=%h want=%h", n, got, want); end
        end
    endtask

    initial begin
        clk = 0;
        total = 0;
        bad = 0;
        model_reset();
        test_reset();
        test_rf_read();
        test_ex_priority();
        test_load_use();
        test_x0();
        test_stall_flush();
        test_wb();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
